note_tone_generator: RTL and testbench

//  Downstream consumer of the audio sequencer's 4-bit noteSelect code. Converts each note code into a

---
 rtl/audio_pkg.sv | 23 ++
 rtl/tone_pwm_gate.sv | 29 ++
 rtl/note_tone_generator.sv | 73 +++++++
 tb/tb_note_tone_generator.sv | 116 +++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared note definitions for the audio sequencer and tone generator:
// note codes, pitch table and half-period lookup.
package audio_pkg;

  localparam logic [3:0] NOTE_A    = 4'd0;
  localparam logic [3:0] NOTE_B    = 4'd1;
  localparam logic [3:0] NOTE_C    = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_E    = 4'd4;
  localparam logic [3:0] NOTE_F    = 4'd5;
  localparam logic [3:0] NOTE_G    = 4'd6;
  localparam logic [3:0] NOTE_REST = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'd8;

  localparam int unsigned NOTE_FREQ [7] = '{440, 494, 523, 587, 659, 698, 784};

  // Cycles per half tone period (integer divide); 0 for every silent code.
  function automatic int unsigned half_period(input logic [3:0] code, input int unsigned clk_hz);
    if (code > NOTE_G) return 0;
    return clk_hz / (2 * NOTE_FREQ[code[2:0]]);
  endfunction

endpackage

// File: rtl/tone_pwm_gate.sv
// Free-running PWM carrier that gates the tone square wave by volume
// and registers the result onto the audio pin.
module tone_pwm_gate #(
  parameter int PWM_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       square,
  input  logic [2:0] volume,
  output logic       audio_out
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty;

  // Volume steps map onto the top three bits of the carrier range.
  assign duty = PWM_W'(volume) << (PWM_W - 3);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      audio_out <= square & (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/note_tone_generator.sv
// Turns the sequencer's 4-bit note code into a volume-gated square wave
// at the note pitch, plus amplifier enable / tone status flags.
module note_tone_generator
  import audio_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int          CNT_W       = 17,
  parameter int          PWM_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] noteSelect,
  input  logic [2:0] volume,
  output logic       audioOut,
  output logic       ampEnable,
  output logic       toneActive
);

  logic [3:0]             note_reg;
  logic [CNT_W-1:0]       cnt;
  logic                   square;
  logic [7:0][CNT_W-1:0]  half_tbl;
  logic [CNT_W-1:0]       half_m1;
  logic                   note_valid;
  logic                   sel_valid;

  // Constant half-period ROM; slot 7 (rest) is unused and holds 0.
  for (genvar i = 0; i < 8; i++) begin : g_half
    localparam int unsigned HP = half_period(4'(i), CLK_FREQ_HZ);
    assign half_tbl[i] = HP[CNT_W-1:0];
  end

  assign note_valid = (note_reg <= NOTE_G);
  assign sel_valid  = (noteSelect <= NOTE_G);
  assign half_m1    = note_valid ? (half_tbl[note_reg[2:0]] - CNT_W'(1)) : '0;

  // A code change restarts the phase high and beats a coincident toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_reg   <= NOTE_REST;
      cnt        <= '0;
      square     <= 1'b0;
      ampEnable  <= 1'b0;
      toneActive <= 1'b0;
    end else begin
      if (noteSelect != note_reg) begin
        note_reg <= noteSelect;
        cnt      <= '0;
        square   <= sel_valid;
      end else if (note_valid && cnt == half_m1) begin
        cnt    <= '0;
        square <= ~square;
      end else if (note_valid) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt    <= '0;
        square <= 1'b0;
      end
      // The next note_reg always equals noteSelect, so its validity is sel_valid.
      ampEnable  <= sel_valid;
      toneActive <= sel_valid;
    end
  end

  tone_pwm_gate #(.PWM_W(PWM_W)) u_pwm (
    .clk       (clk),
    .reset     (reset),
    .square    (square),
    .volume    (volume),
    .audio_out (audioOut)
  );

endmodule

// File: tb/tb_note_tone_generator.sv
// Scoreboard bench for note_tone_generator at 880 kHz (A half=1000, G=561, D=749).
module tb_note_tone_generator;
  import audio_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noteSelect;
  logic [2:0] volume;
  logic       audioOut, ampEnable, toneActive;

  note_tone_generator #(.CLK_FREQ_HZ(880_000), .CNT_W(17), .PWM_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .noteSelect (noteSelect),
    .volume     (volume),
    .audioOut   (audioOut),
    .ampEnable  (ampEnable),
    .toneActive (toneActive)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string tag;
    logic  sq;
    logic  amp;
    logic  aud;
  } exp_t;

  exp_t q[$];
  exp_t x;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rbase = 0;
  logic last_sq = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the entry due at this edge count.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      total++;
      if (x.cyc != cyc || dut.square !== x.sq || ampEnable !== x.amp ||
          toneActive !== x.amp || audioOut !== x.aud) begin
        bad++;
        if (bad <= 20)
          $display("FAIL %s cyc=%0d(due %0d) got sq=%b amp=%b act=%b aud=%b want sq=%b amp=%b act=%b aud=%b",
                   x.tag, cyc, x.cyc, dut.square, ampEnable, toneActive, audioOut,
                   x.sq, x.amp, x.amp, x.aud);
      end
    end
  end

  // Reset edges: everything low, PWM carrier restarts from 0.
  task automatic rst_run(input int n);
    for (int k = 0; k < n; k++) begin
      q.push_back('{cyc + 1, "reset", 1'b0, 1'b0, 1'b0});
      last_sq = 1'b0;
      @(negedge clk);
    end
    rbase = cyc;
  endtask

  // Hold current inputs for n edges; tone started at edge s with half-period h (0 = silent).
  task automatic run(input int n, input int s, input int h, input string tag);
    for (int k = 0; k < n; k++) begin
      int   e;
      logic sq, aud;
      e   = cyc + 1;
      sq  = (h == 0) ? 1'b0 : ((((e - s) / h) % 2) == 0);
      aud = last_sq && ((((e - 1 - rbase) % 256)) < (int'(volume) << 5));
      q.push_back('{e, tag, sq, (h != 0), aud});
      last_sq = sq;
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b1;
    noteSelect = NOTE_A;
    volume     = 3'd7;
    rst_run(3);
    reset = 1'b0;
    run(5000, cyc + 1, 1000, "A_vol7");
    noteSelect = NOTE_G; volume = 3'd0;
    run(2000, cyc + 1, 561, "G_vol0");
    noteSelect = NOTE_A; volume = 3'd7;
    run(1000, cyc + 1, 1000, "A_pre_collide");
    noteSelect = NOTE_G;
    run(700, cyc + 1, 561, "A2G_collide");
    noteSelect = NOTE_REST;
    run(5, 0, 0, "rest");
    noteSelect = NOTE_END;
    run(5, 0, 0, "end");
    noteSelect = 4'd12;
    run(5, 0, 0, "code12");
    noteSelect = NOTE_D; volume = 3'd3;
    run(1600, cyc + 1, 749, "D_vol3");
    reset = 1'b1;
    rst_run(1);
    reset = 1'b0;
    run(800, cyc + 1, 749, "D_restart");
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
